// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment display controller: hex or decimal (double-dabble) display,
// leading-zero blanking, overflow dashes and blinking. Segment outputs are active-low.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int CW = $clog2(VW);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(VW - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;
    localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t          state_reg, state_next;
    logic [VW-1:0]   bin_reg, bin_next;
    logic [VW-1:0]   bcd_reg, bcd_next;
    logic [VW-1:0]   bcd_adj, bcd_shift;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            ovf_acc_reg, ovf_acc_next;
    logic            overflow_reg, overflow_next;
    // Per-digit code: bit 4 marks the dash glyph, bits 3:0 hold the nibble.
    logic [4:0]      digit_reg  [NUM_DIGITS];
    logic [4:0]      digit_next [NUM_DIGITS];
    logic [BW-1:0]   blink_cnt_reg;
    logic            phase_reg;
    logic [SW-1:0]   glyph_all;
    logic [SW-1:0]   hex_out_reg;
    logic [NUM_DIGITS:0] zero_above;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Add-3 correction on every BCD digit before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj[VW-2:0], bin_reg[VW-1]};

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        cnt_next      = cnt_reg;
        ovf_acc_next  = ovf_acc_reg;
        overflow_next = overflow_reg;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_next[i] = digit_reg[i];
        end
        case (state_reg)
            IDLE: begin
                if (load) begin
                    if (dec_mode) begin
                        bin_next     = value;
                        bcd_next     = '0;
                        cnt_next     = '0;
                        ovf_acc_next = 1'b0;
                        state_next   = CONVERT;
                    end else begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            digit_next[i] = {1'b0, value[4*i +: 4]};
                        end
                        overflow_next = 1'b0;
                    end
                end
            end
            CONVERT: begin
                bin_next     = bin_reg << 1;
                bcd_next     = bcd_shift;
                ovf_acc_next = ovf_acc_reg | bcd_adj[VW-1];
                cnt_next     = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit_next[i] = ovf_acc_reg ? 5'b10000 : {1'b0, bcd_reg[4*i +: 4]};
                end
                overflow_next = ovf_acc_reg;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            ovf_acc_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            cnt_reg      <= cnt_next;
            ovf_acc_reg  <= ovf_acc_next;
            overflow_reg <= overflow_next;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= digit_next[i];
            end
        end
    end

    // zero_above[k]: digit k and every digit above it are plain zeros.
    always_comb begin
        zero_above[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (digit_reg[i] == 5'd0);
        end
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph
            if (gi == 0) begin : g_lsd
                assign glyph_all[6:0] = digit_reg[0][4] ? SEG_DASH : seg7(digit_reg[0][3:0]);
            end else begin : g_upper
                assign glyph_all[7*gi +: 7] = digit_reg[gi][4] ? SEG_DASH :
                                              (blank_lz && zero_above[gi]) ? SEG_BLANK :
                                              seg7(digit_reg[gi][3:0]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            hex_out_reg   <= '1;
        end else begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
            hex_out_reg <= (blink_en && phase_reg) ? '1 : glyph_all;
        end
    end

    assign busy     = (state_reg == CONVERT);
    assign overflow = overflow_reg;
    assign hex_out  = hex_out_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (6 digits, blink period 4): vector table,
// randomized loads against a decimal/hex reference model, and multi-cycle corner cases.
module tb_hex_display_ctrl;

    localparam int N = 6;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0011000, G_A = 7'b0001000, G_B = 7'b0000011;
    localparam logic [6:0] G_C = 7'b1000110, G_D = 7'b0100001, G_E = 7'b0000110, G_F = 7'b0001110;
    localparam logic [6:0] DASH = 7'b0111111, BLK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        dec_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [23:0] value = '0;
    logic        busy;
    logic        overflow;
    logic [41:0] hex_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dec_mode(dec_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .overflow(overflow),
        .hex_out(hex_out)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; the time base for the blink pattern.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic        dec;
        logic [23:0] val;
        logic        blz;
        logic [41:0] exp_hex;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return G0;   1: return G1;   2: return G2;   3: return G3;
            4: return G4;   5: return G5;   6: return G6;   7: return G7;
            8: return G8;   9: return G9;   10: return G_A; 11: return G_B;
            12: return G_C; 13: return G_D; 14: return G_E; default: return G_F;
        endcase
    endfunction

    function automatic logic [41:0] model(input logic dec, input logic [23:0] v,
                                          input logic blz, output logic ovf);
        int d [N];
        int n;
        int msnz;
        logic dash;
        logic [41:0] r;
        n = int'(v);
        dash = dec && (n > 999999);
        for (int k = 0; k < N; k++) begin
            if (dec) begin
                d[k] = n % 10;
                n = n / 10;
            end else begin
                d[k] = int'((v >> (4 * k)) & 24'hF);
            end
        end
        msnz = 0;
        for (int k = 0; k < N; k++) if (d[k] != 0) msnz = k;
        for (int k = 0; k < N; k++) begin
            if (dash)                   r[7*k +: 7] = DASH;
            else if (blz && k > msnz)   r[7*k +: 7] = BLK;
            else                        r[7*k +: 7] = glyph(d[k]);
        end
        ovf = dash;
        return r;
    endfunction

    // Count busy cycles; optionally pulse load (with a different value) on busy cycle pulse_at.
    task automatic run_busy(input int pulse_at, input logic [23:0] pulse_val, output int width);
        width = 0;
        while (busy === 1'b1 && width < 100) begin
            width++;
            load = (width == pulse_at);
            if (width == pulse_at) value = pulse_val;
            step();
        end
        load = 1'b0;
    endtask

    task automatic apply(input logic dec, input logic [23:0] v, input logic blz,
                         input int pulse_at, input logic [23:0] pulse_val, output int width);
        dec_mode = dec;
        value    = v;
        blank_lz = blz;
        load     = 1'b1;
        step();
        load  = 1'b0;
        width = 0;
        if (dec) begin
            run_busy(pulse_at, pulse_val, width);
            step();
            step();
        end else begin
            check("hex_busy_low", {63'd0, busy}, 64'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic eo;
        logic [41:0] eh;
        logic [41:0] shown;

        tbl[0]  = '{1'b0, 24'h00A3F0, 1'b0, {G0, G0, G_A, G3, G_F, G0}, 1'b0};
        tbl[1]  = '{1'b1, 24'h0004D2, 1'b0, {G0, G0, G1, G2, G3, G4}, 1'b0};
        tbl[2]  = '{1'b1, 24'h0004D2, 1'b1, {BLK, BLK, G1, G2, G3, G4}, 1'b0};
        tbl[3]  = '{1'b1, 24'h0F4240, 1'b0, {6{DASH}}, 1'b1};
        tbl[4]  = '{1'b0, 24'h000001, 1'b1, {BLK, BLK, BLK, BLK, BLK, G1}, 1'b0};
        tbl[5]  = '{1'b0, 24'h000000, 1'b1, {BLK, BLK, BLK, BLK, BLK, G0}, 1'b0};
        tbl[6]  = '{1'b1, 24'h0F423F, 1'b0, {6{G9}}, 1'b0};
        tbl[7]  = '{1'b0, 24'hFEDCBA, 1'b0, {G_F, G_E, G_D, G_C, G_B, G_A}, 1'b0};
        tbl[8]  = '{1'b1, 24'h000000, 1'b1, {BLK, BLK, BLK, BLK, BLK, G0}, 1'b0};
        tbl[9]  = '{1'b1, 24'h0186A0, 1'b1, {G1, G0, G0, G0, G0, G0}, 1'b0};
        tbl[10] = '{1'b0, 24'h0A0000, 1'b1, {BLK, G_A, G0, G0, G0, G0}, 1'b0};
        tbl[11] = '{1'b1, 24'hFFFFFF, 1'b1, {6{DASH}}, 1'b1};
        tbl[12] = '{1'b0, 24'h000010, 1'b1, {BLK, BLK, BLK, BLK, G1, G0}, 1'b0};

        // Reset state (asynchronous, checked while still in reset)
        #12;
        check("rst_hex_out", {22'd0, hex_out}, {22'd0, {42{1'b1}}});
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_hex_out", {22'd0, hex_out}, {22'd0, {6{G0}}});

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].dec, tbl[i].val, tbl[i].blz, 0, 24'h0, w);
            check($sformatf("tbl%0d_hex", i), {22'd0, hex_out}, {22'd0, tbl[i].exp_hex});
            check($sformatf("tbl%0d_ovf", i), {63'd0, overflow}, {63'd0, tbl[i].exp_ovf});
            if (tbl[i].dec) check($sformatf("tbl%0d_busy_w", i), 64'(w), 64'd24);
            $display("vec %0d: dec=%0d value=%h blz=%0d -> hex_out=%h ovf=%0d busy_w=%0d",
                     i, tbl[i].dec, tbl[i].val, tbl[i].blz, hex_out, overflow, w);
        end

        for (int i = 0; i < 20; i++) begin
            logic        rd;
            logic        rb;
            logic [23:0] rv;
            int          sel;
            rd  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      rv = 24'($urandom_range(0, 999));
            else if (sel == 1) rv = 24'($urandom_range(900000, 1100000));
            else               rv = 24'($urandom);
            eh = model(rd, rv, rb, eo);
            apply(rd, rv, rb, 0, 24'h0, w);
            check($sformatf("rnd%0d_hex", i), {22'd0, hex_out}, {22'd0, eh});
            check($sformatf("rnd%0d_ovf", i), {63'd0, overflow}, {63'd0, eo});
            if (rd) check($sformatf("rnd%0d_busy_w", i), 64'(w), 64'd24);
            $display("rnd %0d: dec=%0d value=%h blz=%0d -> hex_out=%h ovf=%0d",
                     i, rd, rv, rb, hex_out, overflow);
        end

        // Load pulsed mid-conversion is ignored
        apply(1'b1, 24'h0004D2, 1'b0, 5, 24'h0003E7, w);
        check("ign_busy_w", 64'(w), 64'd24);
        check("ign_hex", {22'd0, hex_out}, {22'd0, {G0, G0, G1, G2, G3, G4}});
        step();
        step();
        check("ign_busy_after", {63'd0, busy}, 64'd0);
        $display("ignore-load: busy_w=%0d hex_out=%h", w, hex_out);

        // Blink: value alternates with blank every 4 cycles
        apply(1'b0, 24'h123456, 1'b0, 0, 24'h0, w);
        shown = {G1, G2, G3, G4, G5, G6};
        check("blink_base", {22'd0, hex_out}, {22'd0, shown});
        blink_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            eh = ((((cyc - 1) / 4) % 2) == 1) ? {42{1'b1}} : shown;
            check($sformatf("blink_on_%0d", i), {22'd0, hex_out}, {22'd0, eh});
        end
        blink_en = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("blink_off_%0d", i), {22'd0, hex_out}, {22'd0, shown});
        end
        $display("blink: checked 32 cycles");

        // Reset mid-conversion aborts with no commit
        apply(1'b1, 24'hFFFFFF, 1'b0, 0, 24'h0, w);
        check("r_pre_ovf", {63'd0, overflow}, 64'd1);
        dec_mode = 1'b1;
        value    = 24'h0004D2;
        load     = 1'b1;
        step();
        load = 1'b0;
        w = 0;
        while (busy === 1'b1 && w < 10) begin
            w++;
            step();
        end
        check("r_busy_run", 64'(w), 64'd10);
        rst_n = 1'b0;
        #1;
        check("r_hex_out", {22'd0, hex_out}, {22'd0, {42{1'b1}}});
        check("r_busy", {63'd0, busy}, 64'd0);
        check("r_ovf", {63'd0, overflow}, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("r_no_commit", {22'd0, hex_out}, {22'd0, {6{G0}}});
        check("r_idle_busy", {63'd0, busy}, 64'd0);
        apply(1'b1, 24'h00BEEF, 1'b0, 0, 24'h0, w);
        check("r_next_busy_w", 64'(w), 64'd24);
        check("r_next_hex", {22'd0, hex_out}, {22'd0, {G0, G4, G8, G8, G7, G9}});
        check("r_next_ovf", {63'd0, overflow}, 64'd0);
        $display("reset-abort: next conversion hex_out=%h", hex_out);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
